cpu_mem_copier: RTL and testbench

- Memory-side initiator that drives the port of the team's 1024-word CPU data memory: addr[9:0], writeen, writeint, combinational read data RD.
- On command, it copies a block of words from a source address to a destination address, one word at a time.
- It also accumulates a 32-bit sum of the words copied.
- It sits beside the CPU core as a simple block-copy engine that exercises the memory as a master.

---
 rtl/cpu_mem_copier.sv | 103 ++++++++++
 tb/tb_cpu_mem_copier.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_copier.sv
// Block-copy engine that masters the 1024-word CPU data memory port.
// Copies len words src->dst one word per two cycles and sums the copied data.
module cpu_mem_copier #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] sum,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t        state, next_state;
    logic [AW-1:0] src_ptr, dst_ptr;
    logic [AW:0]   remaining;
    logic [DW-1:0] buffer;
    logic [DW-1:0] sum_acc;

    assign sum = sum_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (start) next_state = (len != '0) ? READ : DONE;
            end
            READ: begin
                busy       = 1'b1;
                mem_addr   = src_ptr;
                next_state = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = dst_ptr;
                mem_wdata  = buffer;
                next_state = (remaining == (AW+1)'(1)) ? DONE : READ;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Pointers wrap naturally at 2^AW, which makes a len=1024 copy cover all of memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            buffer    <= '0;
            sum_acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= len;
                        sum_acc   <= '0;
                    end
                end
                READ: buffer <= mem_rdata;
                WRITE: begin
                    src_ptr   <= src_ptr + AW'(1);
                    dst_ptr   <= dst_ptr + AW'(1);
                    remaining <= remaining - (AW+1)'(1);
                    sum_acc   <= sum_acc + buffer;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_copier.sv
// Directed bench for cpu_mem_copier with a behavioural 1024x32 memory
// (combinational read, write on posedge when mem_we is high).
module tb_cpu_mem_copier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  src_addr;
    logic [9:0]  dst_addr;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [1024];

    int checks = 0;
    int errors = 0;

    cpu_mem_copier #(.AW(10), .DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one command and observes every cycle after the sampling edge.
    // Observation index i is the cycle following the i-th edge after sampling.
    task automatic do_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                           input int poke_at,
                           output int busy_cyc, output int done_cnt,
                           output int done_at, output int we_cnt);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cyc = 0;
        done_cnt = 0;
        done_at  = -1;
        we_cnt   = 0;
        for (int i = 0; i <= 2 * int'(n) + 3; i++) begin
            if (busy) busy_cyc++;
            if (mem_we) we_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (i == poke_at) begin
                src_addr = 10'd0;
                dst_addr = 10'd600;
                len      = 11'd1;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    int bc, dc, da, wc;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'd49;
        mem[1] = 32'd7;
        mem[2] = 32'd2;
        mem[1022] = 32'hAAAA0001;
        mem[1023] = 32'hBBBB0002;
        mem[300] = 32'hFFFFFFFF;
        mem[301] = 32'h00000002;
        mem[400] = 32'd11;
        mem[401] = 32'd22;
        mem[402] = 32'd33;
        mem[600] = 32'hDEAD0600;
        mem[10] = 32'h1111;
        mem[11] = 32'h2222;
        mem[12] = 32'h3333;
        mem[13] = 32'h4444;

        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", {22'b0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_sum", sum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic three-word copy
        do_copy(10'd0, 10'd100, 11'd3, -1, bc, dc, da, wc);
        check("basic_m100", mem[100], 32'd49);
        check("basic_m101", mem[101], 32'd7);
        check("basic_m102", mem[102], 32'd2);
        check("basic_done_cnt", dc, 1);
        check("basic_done_at", da, 6);
        check("basic_busy_cyc", bc, 6);
        check("basic_sum", sum, 32'd58);

        // Zero-length command
        do_copy(10'd5, 10'd9, 11'd0, -1, bc, dc, da, wc);
        check("len0_done_at", da, 0);
        check("len0_done_cnt", dc, 1);
        check("len0_we", wc, 0);
        check("len0_busy", bc, 0);
        check("len0_sum", sum, 32'd0);
        check("len0_m9", mem[9], 32'd0);

        // Source wraps 1023 -> 0
        do_copy(10'd1022, 10'd500, 11'd3, -1, bc, dc, da, wc);
        check("wrap_m500", mem[500], 32'hAAAA0001);
        check("wrap_m501", mem[501], 32'hBBBB0002);
        check("wrap_m502", mem[502], 32'd49);
        check("wrap_done_at", da, 6);

        // Destination wraps 1023 -> 0
        do_copy(10'd0, 10'd1023, 11'd2, -1, bc, dc, da, wc);
        check("dwrap_m1023", mem[1023], 32'd49);
        check("dwrap_m0", mem[0], 32'd7);
        check("dwrap_sum", sum, 32'd56);

        // Sum overflow discards carry
        do_copy(10'd300, 10'd310, 11'd2, -1, bc, dc, da, wc);
        check("ovf_sum", sum, 32'h00000001);
        check("ovf_m311", mem[311], 32'h00000002);

        // start while busy is ignored
        do_copy(10'd400, 10'd410, 11'd3, 2, bc, dc, da, wc);
        check("ign_m410", mem[410], 32'd11);
        check("ign_m411", mem[411], 32'd22);
        check("ign_m412", mem[412], 32'd33);
        check("ign_done_cnt", dc, 1);
        check("ign_done_at", da, 6);
        check("ign_m600", mem[600], 32'hDEAD0600);
        check("ign_sum", sum, 32'd66);

        // Asynchronous reset during WRITE of word 2
        @(negedge clk);
        src_addr = 10'd10;
        dst_addr = 10'd200;
        len      = 11'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_we", {31'b0, mem_we}, 32'd1);
        check("pre_rst_addr", {22'b0, mem_addr}, 32'd201);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_we", {31'b0, mem_we}, 32'd0);
        check("arst_sum", sum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("arst_m200", mem[200], 32'h1111);
        check("arst_m201", mem[201], 32'd0);
        @(negedge clk);
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        check("post_rst_addr", {22'b0, mem_addr}, 32'd0);
        do_copy(10'd12, 10'd250, 11'd1, -1, bc, dc, da, wc);
        check("fresh_m250", mem[250], 32'h3333);
        check("fresh_done_at", da, 2);
        check("fresh_done_cnt", dc, 1);
        check("fresh_sum", sum, 32'h3333);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
